dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  Sits between the CPU MEM stage and the word-organised data RAM.
//  Accepts byte-addressed load/store requests of byte, half or word size.
//  Drives the RAM with word index addr[ADDR_W+1:2]. Byte/half loads return a lane-extracted, sign/zero-extended word.
//  Byte/half stores use read-modify-write, because the RAM has no byte enables.
// PARAMETERS
//  ADDR_W  11  RAM word-index width (RAM holds 2**ADDR_W 32-bit words)
//  RANGE_CHK  1  1: flag error if req_addr[31:ADDR_W+2] != 0; 0: upper bits ignored
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       unit idle; request accepted when req_valid & req_ready
//  req_we      in   1       1 = store, 0 = load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1       loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid  out  1       one-cycle completion pulse; no backpressure
//  resp_rdata  out  32      load result; 0 for stores and errors
//  resp_err    out  1       misaligned, illegal size or out of range; qualified by resp_valid
//  ram_addr    out  ADDR_W  word index
//  ram_re      out  1       read strobe; ram_rdata valid exactly 1 cycle later
//  ram_we      out  1       write strobe
//  ram_wdata   out  32      full word written
//  ram_rdata   in   32      RAM read data
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0.
//   - req_ready=1 (decoded from state==IDLE).
//   - ram_re/ram_we are decoded from state, so a reset mid-operation kills any pending write immediately.
//   - An in-flight request is dropped and gets no response.
//  Request capture: at accept, latch we, size, signed, addr, wdata. Inputs are ignored outside IDLE.
//  Little-endian lanes: lane = addr[1:0]; byte n occupies [8n+7:8n].
//   - Half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
//  Error if any of:
//   - size=11;
//   - half with addr[0]=1;
//   - word with addr[1:0]!=0;
//   - RANGE_CHK=1 and addr[31:ADDR_W+2]!=0.
//   An erroring request never touches the RAM.
//  FSM states: IDLE, RD, WAIT, WR, RESP.
//   - IDLE: on accept -> RESP if error; -> WR if word store; otherwise -> RD.
//   - RD: ram_re=1, ram_addr=index -> WAIT.
//   - WAIT: sample ram_rdata. Load: latch extracted/extended data -> RESP. Partial store: latch merged word -> WR.
//     Merge replaces only the addressed lane(s) with wdata[7:0] or wdata[15:0].
//   - WR: ram_we=1, ram_addr=index, ram_wdata = wdata (word) or merged word -> RESP.
//   - RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready=0 here, so no back-to-back accept.
//  Latency from accept cycle T to resp_valid:
//   - error T+1; word store T+2; load T+3; byte/half store T+4.
//  Extension: byte -> 24 bits of sign (bit 7) or zero; half -> 16 bits of sign (bit 15) or zero. Word passes through.
//  ram_addr holds the index in RD/WR and 0 otherwise; ram_wdata is 0 outside WR.
// TESTING
//  1. Reset mid partial store:
//     - stimulus: rst_n low during WR;
//     - required: ram_we drops asynchronously, no resp_valid, req_ready=1, word unchanged.
//  2. Word store then load:
//     - stimulus: st 0x0000_0010 data 0xDEADBEEF, then lw 0x10 signed;
//     - required: ram_we at T+1 with ram_addr=4; load resp at T+3 with rdata=0xDEADBEEF, err=0.
//  3. Byte RMW:
//     - stimulus: word 4 = 0x11223344, then sb addr 0x11 data 0xAB;
//     - required: RAM word becomes 0x1122AB44; resp at T+4.
//  4. Extension:
//     - stimulus: word 4 = 0x8000_80FF;
//     - required: lb 0x10 signed -> 0xFFFFFFFF; lb 0x10 unsigned -> 0x000000FF;
//       lh 0x12 signed -> 0xFFFF8000; lhu 0x12 -> 0x00008000.
//  5. Errors:
//     - stimulus: lh 0x11; sw 0x12; size=11; addr 0x0000_2000 (RANGE_CHK=1);
//     - required: each gives resp_err=1, rdata=0 at T+1, and no ram_re/ram_we.
//  6. Handshake:
//     - stimulus: hold req_valid high continuously;
//     - required: req_ready=0 from T+1 until after the RESP cycle; the next accept happens on the first IDLE cycle.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// Bundle of CPU-side request/response and RAM-side signals for the data memory access unit.
// valid/ready: a request transfers on a rising edge where req_valid and req_ready are both high;
// the requester holds its payload stable while req_valid is high and req_ready is low.
// resp_valid is a single-cycle pulse with no backpressure.
interface dmem_access_unit_if #(
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_re, ram_we, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_re, ram_we, ram_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Byte-addressed load/store front end for a word-wide RAM without byte enables.
// Sub-word stores are done as read-modify-write; sub-word loads are lane-extracted and extended.
module dmem_access_unit #(
  parameter int ADDR_W    = 11,
  parameter bit RANGE_CHK = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_access_unit_if.slave   bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              range_bad;
  logic              req_err;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  always_comb begin
    range_bad = RANGE_CHK && ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
    req_err   = (bus.req_size == 2'b11)
             || ((bus.req_size == 2'b01) && bus.req_addr[0])
             || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
             || range_bad;
  end

  // Lane extraction and sign/zero extension of the word returned by the RAM.
  always_comb begin
    rd_byte = 8'h00;
    unique case (addr_q[1:0])
      2'd0: rd_byte = bus.ram_rdata[7:0];
      2'd1: rd_byte = bus.ram_rdata[15:8];
      2'd2: rd_byte = bus.ram_rdata[23:16];
      2'd3: rd_byte = bus.ram_rdata[31:24];
    endcase
    rd_half  = addr_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    load_val = bus.ram_rdata;
    if (size_q == 2'b00) begin
      load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
    end else if (size_q == 2'b01) begin
      load_val = {{16{signed_q & rd_half[15]}}, rd_half};
    end
  end

  // Merge replaces only the addressed lane(s) of the old word.
  always_comb begin
    merged = bus.ram_rdata;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = data_q[7:0];
        2'd1: merged[15:8]  = data_q[7:0];
        2'd2: merged[23:16] = data_q[7:0];
        2'd3: merged[31:24] = data_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = data_q[15:0];
    end else begin
      merged[15:0] = data_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      data_q   <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            signed_q <= bus.req_signed;
            size_q   <= bus.req_size;
            addr_q   <= bus.req_addr[ADDR_W+1:0];
            data_q   <= bus.req_wdata;
            rdata_q  <= 32'd0;
            err_q    <= req_err;
            if (req_err) begin
              state_q <= S_RESP;
            end else if (bus.req_we && (bus.req_size == 2'b10)) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD:   state_q <= S_WAIT;
        S_WAIT: begin
          if (we_q) begin
            data_q  <= merged;
            state_q <= S_WR;
          end else begin
            rdata_q <= load_val;
            state_q <= S_RESP;
          end
        end
        S_WR:    state_q <= S_RESP;
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM strobes decode straight from state so reset cancels them without waiting for a clock.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.ram_re     = (state_q == S_RD);
  assign bus.ram_we     = (state_q == S_WR);
  assign bus.ram_addr   = ((state_q == S_RD) || (state_q == S_WR)) ? addr_q[ADDR_W+1:2] : '0;
  assign bus.ram_wdata  = (state_q == S_WR) ? data_q : 32'd0;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed and randomized bench for dmem_access_unit with a RAM model and a byte-mask reference model.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_state;
  int checks = 0;
  int failures = 0;

  logic [31:0] ram_mem [0:2047];
  logic [31:0] ref_mem [0:2047];

  always #5 clk = ~clk;

  dmem_access_unit_if #(.ADDR_W(11)) bus();

  dmem_access_unit #(.ADDR_W(11), .RANGE_CHK(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // Synchronous RAM: read data one cycle after ram_re.
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: alignment by modulo, lane update by byte mask, extension by OR-ing sign bits.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] exp_rdata, output logic exp_err,
                                output int exp_lat);
    int nbytes;
    int sh;
    int idx;
    logic [31:0] raw;
    logic [31:0] mask;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    sh = 8 * int'(addr[1:0]);
    idx = int'(addr[12:2]);
    exp_rdata = 32'd0;
    exp_err = (size == 2'd3) || ((int'(addr[1:0]) % nbytes) != 0) || ((addr >> 13) != 32'd0);
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 3;
      raw = ref_mem[idx] >> sh;
      if (nbytes == 1) begin
        raw = raw & 32'h0000_00FF;
        if (sgn && raw[7]) raw = raw | 32'hFFFF_FF00;
      end else if (nbytes == 2) begin
        raw = raw & 32'h0000_FFFF;
        if (sgn && raw[15]) raw = raw | 32'hFFFF_0000;
      end
      exp_rdata = raw;
    end else if (nbytes == 4) begin
      exp_lat = 2;
      ref_mem[idx] = wdata;
    end else begin
      exp_lat = 4;
      mask = ((nbytes == 1) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << sh) & mask);
    end
  endfunction

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Called at a negedge; returns at a negedge with the unit idle again.
  task automatic run_txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rdata;
    logic exp_err;
    int exp_lat;
    int lat;
    int we_cyc;
    bit seen_re;
    bit seen_we;
    logic [31:0] we_addr;
    logic [31:0] obs_rdata;
    logic obs_err;
    int k;
    int idx;
    model(we, size, sgn, addr, wdata, exp_rdata, exp_err, exp_lat);
    idx = int'(addr[12:2]);
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    drive(we, size, sgn, addr, wdata);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; we_cyc = 0; seen_re = 0; seen_we = 0;
    we_addr = 32'd0; obs_rdata = 32'hx; obs_err = 1'bx;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.ram_re) seen_re = 1'b1;
      if (bus.ram_we && !seen_we) begin
        seen_we = 1'b1;
        we_cyc = n;
        we_addr = 32'(bus.ram_addr);
      end
      if (bus.resp_valid) begin
        lat = n;
        obs_rdata = bus.resp_rdata;
        obs_err = bus.resp_err;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " err"}, 32'(obs_err), 32'(exp_err));
    check({tag, " rdata"}, obs_rdata, exp_rdata);
    if (exp_err) begin
      check({tag, " ram_untouched"}, 32'({seen_re, seen_we}), 32'd0);
    end else if (we) begin
      check({tag, " we_cycle"}, 32'(we_cyc), 32'(exp_lat - 1));
      check({tag, " we_addr"}, we_addr, 32'(idx));
      check({tag, " ram_word"}, ram_mem[idx], ref_mem[idx]);
    end
    @(negedge clk);
    check({tag, " pulse_end"}, 32'({bus.resp_valid, bus.req_ready}), 32'b01);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    logic [31:0] saved;
    bit any_resp;
    bus.req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    bus.req_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst ready", 32'(bus.req_ready), 32'd1);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst rdata", bus.resp_rdata, 32'd0);
    check("rst err", 32'(bus.resp_err), 32'd0);
    check("rst ram_re_we", 32'({bus.ram_re, bus.ram_we}), 32'd0);
    check("rst ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst ram_wdata", bus.ram_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload the working region with word stores
    for (int w = 0; w < 16; w++) begin
      run_txn($sformatf("pre%0d", w), 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);
    end

    // Word store then load
    run_txn("sw_dead", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    run_txn("lw_dead", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    check("lw_dead const", ref_mem[4], 32'hDEADBEEF);

    // Byte read-modify-write
    run_txn("sw_1122", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    run_txn("sb_ab", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB);
    check("sb_ab word", ram_mem[4], 32'h1122AB44);

    // Extension
    run_txn("sw_8000", 1'b1, 2'b10, 1'b0, 32'h10, 32'h800080FF);
    run_txn("lb_s", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    run_txn("lb_u", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    run_txn("lh_s", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    run_txn("lh_u", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);

    // Errors
    run_txn("err_lh_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    run_txn("err_sw_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678);
    run_txn("err_size", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    run_txn("err_range", 1'b1, 2'b10, 1'b0, 32'h2000, 32'hCAFEF00D);

    // Handshake with req_valid held high: two loads of word 4 back to back
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check($sformatf("hs ready n%0d", n), 32'(bus.req_ready), 32'((n == 4) || (n == 8)));
      check($sformatf("hs resp n%0d", n), 32'(bus.resp_valid), 32'((n == 3) || (n == 7)));
      if (n == 3 || n == 7) check($sformatf("hs rdata n%0d", n), bus.resp_rdata, 32'h800080FF);
      if (n == 5) bus.req_valid = 1'b0;
    end

    // Reset during the write phase of a byte store
    saved = ref_mem[5];
    drive(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000005A);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid we_before", 32'(bus.ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid we_drop", 32'(bus.ram_we), 32'd0);
    check("rst_mid ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid resp", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) any_resp = 1'b1;
    end
    check("rst_mid no_resp", 32'(any_resp), 32'd0);
    check("rst_mid word", ram_mem[5], saved);

    // Randomized traffic over words 0..15 with occasional out-of-range addresses
    for (int t = 0; t < 250; t++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(13, 31));
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
